// File: rtl/adc_burst_scheduler.sv
// adc_burst_scheduler: round-robin burst arbiter merging NCH channel FIFOs into one 32-bit stream.
// Define ADC_BURST_HEADER_EN to prefix every burst with a header word.
module adc_burst_scheduler #(
  parameter int NCH  = 4,
  parameter int CH_W = 4
) (
  input  logic              BUS_CLK,
  input  logic              BUS_RST_N,
  input  logic              ENABLE,
  input  logic [7:0]        BURST_LEN,
  input  logic [NCH-1:0]    REQ,
  input  logic [NCH*32-1:0] DATA_IN,
  output logic [NCH-1:0]    READ_GRANT,
  input  logic              NEAR_FULL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [31:0]       DATA_OUT,
  output logic [CH_W-1:0]   CUR_CH,
  output logic              BUSY,
  output logic [31:0]       WORD_CNT
);
`ifdef ADC_BURST_HEADER_EN
  typedef enum logic [1:0] {ARB, BURST, HDR} state_t;
  logic [15:0] seq;
`else
  typedef enum logic [1:0] {ARB, BURST} state_t;
`endif
  state_t state;
  logic [7:0] cnt, limit;
  logic [CH_W-1:0] nxt;
  logic [NCH-1:0] rot;
  logic [31:0] din_cur;
  logic req_cur, can_load, accept, pop;
  assign can_load = !OUT_VALID || OUT_READY;
  assign accept = OUT_VALID && OUT_READY;
  assign req_cur = 1'(REQ >> CUR_CH);
  assign din_cur = 32'(DATA_IN >> {CUR_CH, 5'd0});
  assign pop = state == BURST && req_cur && ENABLE && can_load;
  assign READ_GRANT = pop ? NCH'(1) << CUR_CH : '0;
  assign BUSY = state != ARB;
  // rot[j] is the request of channel (CUR_CH+1+j) mod NCH
  assign rot = NCH'({REQ, REQ} >> (CUR_CH + CH_W'(1)));
  always_comb begin
    nxt = CUR_CH;
    for (int j = NCH - 1; j >= 0; j--)
      if (rot[j]) nxt = CH_W'((int'(CUR_CH) + 1 + j) % NCH);
  end
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N)
    if (!BUS_RST_N) begin
      state <= ARB;
      CUR_CH <= CH_W'(NCH - 1);
      cnt <= 8'd0;
      limit <= 8'd1;
      OUT_VALID <= 1'b0;
      DATA_OUT <= 32'd0;
      WORD_CNT <= 32'd0;
`ifdef ADC_BURST_HEADER_EN
      seq <= 16'd0;
`endif
    end else begin
      if (accept) WORD_CNT <= WORD_CNT + 32'd1;
      if (accept) OUT_VALID <= 1'b0;
      case (state)
        ARB: if (ENABLE && !NEAR_FULL && |REQ) begin
          CUR_CH <= nxt;
          limit <= BURST_LEN == 8'd0 ? 8'd1 : BURST_LEN;
          cnt <= 8'd0;
`ifdef ADC_BURST_HEADER_EN
          state <= HDR;
`else
          state <= BURST;
`endif
        end
`ifdef ADC_BURST_HEADER_EN
        HDR: if (can_load) begin
          DATA_OUT <= {8'hA5, 4'h0, 4'(CUR_CH), seq};
          OUT_VALID <= 1'b1;
          seq <= seq + 16'd1;
          state <= BURST;
        end
`endif
        BURST: if (pop) begin
          DATA_OUT <= din_cur;
          OUT_VALID <= 1'b1;
          cnt <= cnt + 8'd1;
          if (cnt + 8'd1 == limit) state <= ARB;
        end else if (!req_cur || !ENABLE) state <= ARB;
        default: state <= ARB;
      endcase
    end
endmodule

// File: tb/tb_adc_burst_scheduler.sv
// tb_adc_burst_scheduler: randomized bench with a burst-level round-robin model and a word scoreboard.
module tb_adc_burst_scheduler;
  localparam int NCH = 4;
  localparam int CH_W = 4;
`ifdef ADC_BURST_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  logic BUS_CLK, BUS_RST_N, ENABLE, NEAR_FULL, OUT_VALID, OUT_READY, BUSY;
  logic [7:0] BURST_LEN;
  logic [NCH-1:0] REQ, READ_GRANT;
  logic [NCH*32-1:0] DATA_IN;
  logic [31:0] DATA_OUT, WORD_CNT;
  logic [CH_W-1:0] CUR_CH;
  adc_burst_scheduler #(.NCH(NCH), .CH_W(CH_W)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .ENABLE(ENABLE), .BURST_LEN(BURST_LEN),
    .REQ(REQ), .DATA_IN(DATA_IN), .READ_GRANT(READ_GRANT), .NEAR_FULL(NEAR_FULL),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .DATA_OUT(DATA_OUT), .CUR_CH(CUR_CH),
    .BUSY(BUSY), .WORD_CNT(WORD_CNT)
  );
  initial BUS_CLK = 1'b0;
  always #5 BUS_CLK = ~BUS_CLK;
  int n_tests = 0, n_fail = 0;
  logic [31:0] fq [NCH][$];
  logic [31:0] exp_q [$];
  int m_last = NCH - 1, m_words = 0, n_pops = 0, cyc = 0, first_g = -1, last_g = -1;
  logic [15:0] m_seq = 16'd0;
  logic [NCH-1:0] g_s = '0;
  logic acc_s = 1'b0, hold = 1'b0;
  logic [31:0] d_s, hold_d;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic drive_fifo();
    for (int c = 0; c < NCH; c++) begin
      REQ[c] = fq[c].size() != 0;
      DATA_IN[32*c +: 32] = fq[c].size() != 0 ? fq[c][0] : 32'hDEAD0000 | 32'(c);
    end
  endtask
  task automatic load(input int c, input int n);
    for (int k = 0; k < n; k++) fq[c].push_back({4'(c), 28'($urandom)});
  endtask
  // Expected stream: visit channels round-robin, each burst takes min(limit, words left)
  task automatic plan(input int blen);
    int left [NCH];
    int pos [NCH];
    int l, c, n;
    bit found;
    l = blen == 0 ? 1 : blen;
    c = 0;
    for (int k = 0; k < NCH; k++) begin
      left[k] = fq[k].size();
      pos[k] = 0;
    end
    forever begin
      found = 0;
      for (int k = 1; k <= NCH && !found; k++) begin
        c = (m_last + k) % NCH;
        if (left[c] > 0) found = 1;
      end
      if (!found) break;
      m_last = c;
`ifdef ADC_BURST_HEADER_EN
      exp_q.push_back({8'hA5, 4'h0, 4'(c), m_seq});
      m_seq++;
      m_words++;
`endif
      n = left[c] < l ? left[c] : l;
      for (int k = 0; k < n; k++) exp_q.push_back(fq[c][pos[c] + k]);
      pos[c] += n;
      left[c] -= n;
      m_words += n;
    end
  endtask
  function automatic bit fifos_empty();
    for (int c = 0; c < NCH; c++) if (fq[c].size() != 0) return 0;
    return 1;
  endfunction
  always @(negedge BUS_CLK) begin
    g_s = BUS_RST_N ? READ_GRANT : '0;
    acc_s = BUS_RST_N && OUT_VALID && OUT_READY;
    d_s = DATA_OUT;
    if (BUS_RST_N && READ_GRANT != '0) begin
      check("grant_onehot", 32'($countones(READ_GRANT)), 1);
      check("grant_load", 32'(OUT_VALID && !OUT_READY), 0);
    end
    if (BUS_RST_N && hold) check("data_hold", DATA_OUT, hold_d);
    hold = BUS_RST_N && OUT_VALID && !OUT_READY;
    hold_d = DATA_OUT;
  end
  always @(posedge BUS_CLK) begin
    #1;
    cyc++;
    if (BUS_RST_N) begin
      for (int c = 0; c < NCH; c++)
        if (g_s[c]) begin
          check("pop_avail", 32'(fq[c].size() != 0), 1);
          if (fq[c].size() != 0) void'(fq[c].pop_front());
          n_pops++;
          if (first_g < 0) first_g = cyc;
          last_g = cyc;
        end
      if (acc_s) begin
        if (exp_q.size() == 0) check("extra_word", 32'(exp_q.size()), 1);
        else check("data", d_s, exp_q.pop_front());
      end
    end
    g_s = '0;
    acc_s = 1'b0;
    drive_fifo();
  end
  task automatic run_until_idle(input int mode, input bit nf);
    for (int k = 0; k < 2000; k++) begin
      @(posedge BUS_CLK);
      #1;
      OUT_READY = mode == 0 ? 1'b1 : mode == 1 ? ~OUT_READY : ($urandom % 3 != 0);
      NEAR_FULL = nf ? ($urandom % 5 == 0) : 1'b0;
      if (exp_q.size() == 0 && fifos_empty() && !BUSY && !OUT_VALID) break;
    end
    OUT_READY = 1'b1;
    NEAR_FULL = 1'b0;
    check("drain", 32'(exp_q.size()), 0);
    check("word_cnt", WORD_CNT, 32'(m_words));
  endtask
  initial begin
    int base;
    logic [5:0] pat;
    BUS_RST_N = 1'b0;
    ENABLE = 1'b1;
    NEAR_FULL = 1'b0;
    OUT_READY = 1'b1;
    BURST_LEN = 8'd4;
    REQ = '0;
    DATA_IN = '0;
    repeat (2) @(posedge BUS_CLK);
    #1;
    check("rst_grant", 32'(READ_GRANT), 0);
    check("rst_valid", 32'(OUT_VALID), 0);
    check("rst_data", DATA_OUT, 0);
    check("rst_cur_ch", 32'(CUR_CH), NCH - 1);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_word_cnt", WORD_CNT, 0);
    @(negedge BUS_CLK);
    BUS_RST_N = 1'b1;
    // single channel, 10 words, bursts of 4
    @(posedge BUS_CLK);
    #1;
    BURST_LEN = 8'd4;
    load(2, 10);
    plan(4);
    drive_fifo();
    first_g = -1;
    run_until_idle(0, 0);
    check("span_4_4_2", 32'(last_g - first_g + 1), 32'(10 + 2 * (1 + HDR)));
    check("cur_ch_2", 32'(CUR_CH), 2);
    // zero burst length gives single-word bursts
    @(posedge BUS_CLK);
    #1;
    BURST_LEN = 8'd0;
    load(1, 3);
    plan(0);
    drive_fifo();
    for (int k = 0; k < 20; k++) begin
      @(negedge BUS_CLK);
      if (BUSY) break;
    end
    pat = HDR ? 6'b110110 : 6'b101010;
    for (int i = 0; i < 6; i++) begin
      check("busy_pat", 32'(BUSY), 32'(pat[5-i]));
      @(negedge BUS_CLK);
    end
    run_until_idle(0, 0);
    // near-full mid-burst lets the running burst finish
    @(posedge BUS_CLK);
    #1;
    BURST_LEN = 8'd8;
    base = m_words;
    load(0, 20);
    plan(8);
    drive_fifo();
    for (int k = 0; k < 20; k++) begin
      @(negedge BUS_CLK);
      if (READ_GRANT != '0) break;
    end
    @(posedge BUS_CLK);
    #1;
    NEAR_FULL = 1'b1;
    repeat (15) @(posedge BUS_CLK);
    #2;
    check("nf_words", WORD_CNT, 32'(base + 8 + HDR));
    check("nf_busy", 32'(BUSY), 0);
    check("nf_left", 32'(fq[0].size()), 12);
    run_until_idle(0, 0);
    // asynchronous reset mid-burst
    @(posedge BUS_CLK);
    #1;
    base = n_pops;
    load(1, 6);
    plan(8);
    drive_fifo();
    for (int k = 0; k < 30; k++) begin
      @(posedge BUS_CLK);
      #1;
      if (n_pops >= base + 3) break;
    end
    #1;
    BUS_RST_N = 1'b0;
    #1;
    check("arst_grant", 32'(READ_GRANT), 0);
    check("arst_valid", 32'(OUT_VALID), 0);
    check("arst_data", DATA_OUT, 0);
    check("arst_cur_ch", 32'(CUR_CH), NCH - 1);
    check("arst_busy", 32'(BUSY), 0);
    check("arst_word_cnt", WORD_CNT, 0);
    for (int c = 0; c < NCH; c++) fq[c].delete();
    exp_q.delete();
    m_last = NCH - 1;
    m_seq = 16'd0;
    m_words = 0;
    drive_fifo();
    @(negedge BUS_CLK);
    BUS_RST_N = 1'b1;
    @(posedge BUS_CLK);
    #1;
    BURST_LEN = 8'd4;
    load(0, 2);
    load(2, 2);
    plan(4);
    drive_fifo();
    for (int k = 0; k < 20; k++) begin
      @(negedge BUS_CLK);
      if (READ_GRANT != '0) break;
    end
    check("first_grant", 32'(READ_GRANT), 1);
    run_until_idle(0, 0);
    // randomized rounds with backpressure and near-full noise
    for (int r = 0; r < 25; r++) begin
      int bl, tot;
      @(posedge BUS_CLK);
      #1;
      bl = $urandom_range(0, 6);
      bl = bl == 6 ? 255 : bl;
      BURST_LEN = 8'(bl);
      tot = 0;
      for (int c = 0; c < NCH; c++) begin
        int n;
        n = $urandom_range(0, 9);
        load(c, n);
        tot += n;
      end
      if (tot == 0) load($urandom_range(0, NCH - 1), 1);
      plan(bl);
      drive_fifo();
      run_until_idle($urandom_range(0, 2), 1'($urandom % 2));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
